// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin two-port sequencer sharing one LIFO stack.
// Each op runs IDLE->ISSUE->WAIT->ACK; occupancy is tracked locally.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   rN_push/rN_pop/rN_din level requests and push data, port N = 0,1
//   rN_ack/rN_err         one-cycle completion pulse and refusal flag
//   rN_dout               last value popped by port N
//   stack_push/stack_pop  single-cycle strobes to the stack
//   stack_din/stack_dout  data to / top-of-stack from the stack
//   count                 current occupancy, 0..DEPTH
module stack_arbiter #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_push,
  input  logic          r0_pop,
  input  logic [DW-1:0] r0_din,
  input  logic          r1_push,
  input  logic          r1_pop,
  input  logic [DW-1:0] r1_din,
  output logic          r0_ack,
  output logic          r0_err,
  output logic [DW-1:0] r0_dout,
  output logic          r1_ack,
  output logic          r1_err,
  output logic [DW-1:0] r1_dout,
  output logic          stack_push,
  output logic          stack_pop,
  output logic [DW-1:0] stack_din,
  input  logic [DW-1:0] stack_dout,
  output logic [CW-1:0] count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]    r_state;
  logic          r_last;
  logic          r_gnt;
  logic          r_err;
  logic [CW-1:0] r_count;

  logic          w_req0;
  logic          w_req1;
  logic          w_sel;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_din;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_err;

  assign w_req0 = r0_push | r0_pop;
  assign w_req1 = r1_push | r1_pop;

  // On a tie the port that was not granted last wins;
  // otherwise the lone requester wins.
  assign w_sel  = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_push = w_sel ? r1_push : r0_push;
  assign w_pop  = w_sel ? r1_pop  : r0_pop;
  assign w_din  = w_sel ? r1_din  : r0_din;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = w_push & ~w_pop & ~w_full;
  assign w_do_pop  = w_pop & ~w_push & ~w_empty;
  // Illegal (both set), overflow and underflow all refuse.
  assign w_err     = ~(w_do_push | w_do_pop);

  assign count = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= '0;
      r0_ack     <= 1'b0;
      r0_err     <= 1'b0;
      r0_dout    <= '0;
      r1_ack     <= 1'b0;
      r1_err     <= 1'b0;
      r1_dout    <= '0;
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
      stack_din  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_gnt      <= w_sel;
            r_err      <= w_err;
            stack_push <= w_do_push;
            stack_pop  <= w_do_pop;
            stack_din  <= w_din;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          stack_push <= 1'b0;
          stack_pop  <= 1'b0;
          if (stack_push) r_count <= r_count + 1'b1;
          if (stack_pop) begin
            r_count <= r_count - 1'b1;
            // Top-of-stack before the pop lands.
            if (r_gnt) r1_dout <= stack_dout;
            else       r0_dout <= stack_dout;
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r0_ack  <= ~r_gnt;
          r0_err  <= ~r_gnt & r_err;
          r1_ack  <= r_gnt;
          r1_err  <= r_gnt & r_err;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r0_ack  <= 1'b0;
          r0_err  <= 1'b0;
          r1_ack  <= 1'b0;
          r1_err  <= 1'b0;
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed vector bench for stack_arbiter
// with a behavioural LIFO standing in for the stack datapath.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       r0_push, r0_pop, r1_push, r1_pop;
  logic [7:0] r0_din, r1_din;
  logic       r0_ack, r0_err, r1_ack, r1_err;
  logic [7:0] r0_dout, r1_dout;
  logic       stack_push, stack_pop;
  logic [7:0] stack_din, stack_dout;
  logic [4:0] count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  stack_arbiter #(.DW(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .r0_push(r0_push), .r0_pop(r0_pop), .r0_din(r0_din),
    .r1_push(r1_push), .r1_pop(r1_pop), .r1_din(r1_din),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_dout(r0_dout),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_dout(r1_dout),
    .stack_push(stack_push), .stack_pop(stack_pop),
    .stack_din(stack_din), .stack_dout(stack_dout),
    .count(count)
  );

  logic [7:0] mem [0:15];
  int sp;
  always @(posedge clk or negedge reset) begin
    if (!reset) sp <= 0;
    else if (stack_push && sp < 16) begin
      mem[sp] <= stack_din;
      sp <= sp + 1;
    end else if (stack_pop && sp > 0) sp <= sp - 1;
  end
  assign stack_dout = (sp > 0) ? mem[sp-1] : 8'h00;

  typedef struct {
    int         port;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic       e_err;
    logic       e_sp;
    logic       e_spop;
    logic [7:0] e_dout;
    int         e_count;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    int p, logic pu, logic po, logic [7:0] d,
    logic er, logic s1, logic s2,
    logic [7:0] dout, int c);
    vec_t v;
    v.port = p; v.push = pu; v.pop = po; v.din = d;
    v.e_err = er; v.e_sp = s1; v.e_spop = s2;
    v.e_dout = dout; v.e_count = c;
    return v;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic set_req(input int p, input logic pu,
                         input logic po, input logic [7:0] d);
    if (p == 0) begin
      r0_push = pu; r0_pop = po; r0_din = d;
    end else begin
      r1_push = pu; r1_pop = po; r1_din = d;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    set_req(v.port, v.push, v.pop, v.din);
    @(negedge clk);
    chk({t, " issue stack_push"}, stack_push, v.e_sp);
    chk({t, " issue stack_pop"}, stack_pop, v.e_spop);
    if (v.e_sp) chk({t, " stack_din"}, stack_din, v.din);
    chk({t, " issue acks"}, r0_ack | r1_ack, 0);
    @(negedge clk);
    chk({t, " wait strobes"}, stack_push | stack_pop, 0);
    chk({t, " wait acks"}, r0_ack | r1_ack, 0);
    @(negedge clk);
    if (v.port == 0) begin
      chk({t, " r0_ack"}, r0_ack, 1);
      chk({t, " r1_ack"}, r1_ack, 0);
      chk({t, " r0_err"}, r0_err, v.e_err);
      chk({t, " r0_dout"}, r0_dout, v.e_dout);
    end else begin
      chk({t, " r1_ack"}, r1_ack, 1);
      chk({t, " r0_ack"}, r0_ack, 0);
      chk({t, " r1_err"}, r1_err, v.e_err);
      chk({t, " r1_dout"}, r1_dout, v.e_dout);
    end
    set_req(v.port, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk({t, " count"}, count, v.e_count);
    chk({t, " idle acks"}, r0_ack | r1_ack, 0);
  endtask

  task automatic chk_reset_outs(input string t);
    chk({t, " acks"}, {r0_ack, r1_ack}, 0);
    chk({t, " errs"}, {r0_err, r1_err}, 0);
    chk({t, " strobes"}, {stack_push, stack_pop}, 0);
    chk({t, " stack_din"}, stack_din, 0);
    chk({t, " r0_dout"}, r0_dout, 0);
    chk({t, " r1_dout"}, r1_dout, 0);
    chk({t, " count"}, count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00);

    vq.push_back(mk(0, 1, 0, 8'hA5, 0, 1, 0, 8'h00, 1));
    vq.push_back(mk(1, 0, 1, 8'h00, 0, 0, 1, 8'hA5, 0));
    vq.push_back(mk(0, 1, 0, 8'h11, 0, 1, 0, 8'h00, 1));
    vq.push_back(mk(1, 0, 1, 8'h00, 0, 0, 1, 8'h11, 0));
    vq.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 8'h11, 0));
    vq.push_back(mk(0, 1, 1, 8'h5A, 1, 0, 0, 8'h00, 0));
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        vq.push_back(mk(0, 1, 0, 8'(8'h20 + i),
                        0, 1, 0, 8'h00, i + 1));
      else
        vq.push_back(mk(1, 1, 0, 8'(8'h20 + i),
                        0, 1, 0, 8'h11, i + 1));
    end
    vq.push_back(mk(1, 1, 0, 8'hEE, 1, 0, 0, 8'h11, 16));
    vq.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 8'h2F, 15));
    vq.push_back(mk(1, 0, 1, 8'h00, 0, 0, 1, 8'h2E, 14));

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b1;
    @(negedge clk);

    foreach (vq[i]) run_vec(vq[i], i);

    // Reset during WAIT of a push aborts with no ack.
    set_req(0, 1'b1, 1'b0, 8'h77);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outs("midop");
    set_req(0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("midop no ack", r0_ack, 0);
    reset = 1'b1;
    @(negedge clk);
    run_vec(mk(1, 0, 1, 8'h00, 1, 0, 0, 8'h00, 0), 100);

    // Simultaneous requests after reset: r0 first both times.
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h01);
    set_req(1, 1'b1, 1'b0, 8'h02);
    repeat (3) @(negedge clk);
    chk("pair1 r0_ack", r0_ack, 1);
    chk("pair1 r1_ack held", r1_ack, 0);
    set_req(0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("pair1 count", count, 1);
    repeat (3) @(negedge clk);
    chk("pair1 r1_ack", r1_ack, 1);
    chk("pair1 r0_ack", r0_ack, 0);
    chk("pair1 r1_err", r1_err, 0);
    set_req(1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("pair1 count2", count, 2);
    set_req(0, 1'b0, 1'b1, 8'h00);
    set_req(1, 1'b0, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    chk("pair2 r0_ack", r0_ack, 1);
    chk("pair2 r1_ack held", r1_ack, 0);
    chk("pair2 r0_dout", r0_dout, 8'h02);
    set_req(0, 1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    chk("pair2 r1_ack", r1_ack, 1);
    chk("pair2 r1_dout", r1_dout, 8'h01);
    set_req(1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("pair2 count", count, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
